// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the
// IF/ID register feeding decode. Handles stalls, redirects and HALT freeze.
module fetch_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        validOut,
  output logic        halted,
  output logic        err
);

  // Handshake: decode consumes instrOut/nextPcOut whenever validOut=1; a stall
  // holds everything (no consumption), a redirect replaces the slot with a bubble.
  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        is_halt;

  assign pc_plus2 = pc + 16'd2;
  assign is_halt  = (imemData[15:11] == 5'b00000);
  assign imemAddr = pc;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      instrOut  <= NOP_INSTR;
      nextPcOut <= 16'h0000;
      validOut  <= 1'b0;
      state     <= RUN;
      err       <= 1'b0;
    end else if (redirect) begin
      // Redirect overrides a stall; an odd target is aligned and flagged.
      pc        <= {redirectPc[15:1], 1'b0};
      instrOut  <= NOP_INSTR;
      nextPcOut <= 16'h0000;
      validOut  <= 1'b0;
      state     <= RUN;
      if (redirectPc[0]) err <= 1'b1;
    end else if (!stall) begin
      case (state)
        RUN: begin
          instrOut  <= imemData;
          nextPcOut <= pc_plus2;
          validOut  <= 1'b1;
          if (is_halt) state <= HALTED;
          else         pc    <= pc_plus2;
        end
        default: begin
          instrOut  <= NOP_INSTR;
          nextPcOut <= 16'h0000;
          validOut  <= 1'b0;
          state     <= HALTED;
        end
      endcase
    end
  end

endmodule
